mem_access_sequencer: RTL and testbench

//  Load/store sequencer between the EX stage and datamemory; it drives datamemory's

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/mem_access_sequencer_if.sv | 33 +++
 rtl/mem_access_sequencer_load_align_extract.sv | 27 ++
 rtl/mem_access_sequencer.sv | 163 ++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store sequencer.
// Funct3 values follow RV32I instr[14:12].
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_HI   = 2'd1,
    ST_BYTE = 2'd2
  } lsu_state_t;

  // Halfwords are misaligned on an odd address, words on any non-zero offset.
  // Store funct3 shares the load encoding, so one helper serves both.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] offset);
    case (funct3)
      F3_LH, F3_LHU: is_misaligned = offset[0];
      F3_LW:         is_misaligned = (offset != 2'b00);
      default:       is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Core-side request/response and datamemory-side signals of the sequencer.
// The slave modport is the sequencer's view; master is the core+memory side.
interface mem_access_sequencer_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  stall;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  mem_read;
  logic                  mem_write;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [2:0]            mem_funct3;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output stall, resp_valid, resp_rdata,
           mem_read, mem_write, mem_addr, mem_wdata, mem_funct3
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  stall, resp_valid, resp_rdata,
           mem_read, mem_write, mem_addr, mem_wdata, mem_funct3
  );
endinterface

// File: rtl/mem_access_sequencer_load_align_extract.sv
// Picks a byte/half/word out of a two-word little-endian window and extends it.
// Purely combinational; shared by split loads and the local LHU path.
module load_align_extract
  import lsu_pkg::*;
(
  input  logic [63:0] window,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    shifted = 32'(window >> {offset, 3'b000});
    result  = shifted;
    case (funct3)
      F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  result = {24'h0, shifted[7:0]};
      F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  result = {16'h0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Load/store sequencer: aligned accesses pass straight to datamemory, misaligned
// ones become two LWs (loads) or a run of SBs (stores) while the core stalls.
module mem_access_sequencer
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic clk,
  input  logic rst_n,
  mem_access_sequencer_if.slave bus
);

  lsu_state_t            state;
  logic [1:0]            cnt;
  logic [1:0]            last_q;
  logic [DATA_W-1:0]     lo_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [2:0]            f3_q;
  logic [DM_ADDRESS-1:0] addr_q;

  logic                  misaligned;
  logic                  split_ld;
  logic                  split_st;
  logic                  local_lhu;
  logic [DM_ADDRESS-1:0] req_base;
  logic [DM_ADDRESS-1:0] lat_base;
  logic [63:0]           ext_window;
  logic [1:0]            ext_offset;
  logic [2:0]            ext_funct3;
  logic [31:0]           ext_rdata;

  assign misaligned = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
  assign split_ld   = bus.req_valid && !bus.req_we && misaligned &&
                      (bus.req_funct3 inside {F3_LH, F3_LHU, F3_LW});
  assign split_st   = bus.req_valid && bus.req_we && misaligned &&
                      (bus.req_funct3 inside {F3_SH, F3_SW});
  // datamemory has no LHU, so an aligned LHU reads the word and extracts here.
  assign local_lhu  = bus.req_valid && !bus.req_we && !misaligned &&
                      (bus.req_funct3 == F3_LHU);
  assign req_base   = {bus.req_addr[DM_ADDRESS-1:2], 2'b00};
  assign lat_base   = {addr_q[DM_ADDRESS-1:2], 2'b00};

  always_comb begin
    if (state == LD_HI) begin
      ext_window = {bus.mem_rdata, lo_q};
      ext_offset = addr_q[1:0];
      ext_funct3 = f3_q;
    end else begin
      ext_window = {32'h0, bus.mem_rdata};
      ext_offset = bus.req_addr[1:0];
      ext_funct3 = F3_LHU;
    end
  end

  load_align_extract u_extract (
    .window (ext_window),
    .offset (ext_offset),
    .funct3 (ext_funct3),
    .result (ext_rdata)
  );

  always_comb begin
    bus.stall      = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = bus.mem_rdata;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = bus.req_addr;
    bus.mem_wdata  = bus.req_wdata;
    bus.mem_funct3 = bus.req_funct3;
    case (state)
      IDLE: begin
        if (bus.req_valid && bus.req_we) begin
          bus.mem_write = 1'b1;
          if (split_st) begin
            bus.mem_funct3 = F3_SB;
            bus.mem_wdata  = {{(DATA_W-8){1'b0}}, bus.req_wdata[7:0]};
            bus.stall      = 1'b1;
          end
        end else if (bus.req_valid) begin
          bus.mem_read = 1'b1;
          if (split_ld) begin
            bus.mem_addr   = req_base;
            bus.mem_funct3 = F3_LW;
            bus.stall      = 1'b1;
          end else begin
            bus.resp_valid = 1'b1;
            if (local_lhu) begin
              bus.mem_addr   = req_base;
              bus.mem_funct3 = F3_LW;
              bus.resp_rdata = ext_rdata;
            end
          end
        end
      end
      LD_HI: begin
        bus.mem_read   = 1'b1;
        bus.mem_addr   = lat_base + DM_ADDRESS'(4);
        bus.mem_funct3 = F3_LW;
        bus.resp_valid = 1'b1;
        bus.resp_rdata = ext_rdata;
      end
      ST_BYTE: begin
        bus.mem_write  = 1'b1;
        bus.mem_addr   = addr_q + DM_ADDRESS'(cnt);
        bus.mem_funct3 = F3_SB;
        bus.mem_wdata  = {{(DATA_W-8){1'b0}}, wdata_q[{cnt, 3'b000} +: 8]};
        bus.stall      = (cnt != last_q);
      end
      default: ;
    endcase
    // Reset is asynchronous, so the control strobes must drop the moment rst_n falls.
    if (!rst_n) begin
      bus.stall      = 1'b0;
      bus.resp_valid = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments only; combinational logic above uses blocking.
  // NOTE: every register here is control/latch state, so all of it is reset (there is no storage array).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      last_q  <= 2'd0;
      lo_q    <= '0;
      wdata_q <= '0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (split_ld) begin
            lo_q   <= bus.mem_rdata;
            f3_q   <= bus.req_funct3;
            addr_q <= bus.req_addr;
            state  <= LD_HI;
          end else if (split_st) begin
            wdata_q <= bus.req_wdata;
            addr_q  <= bus.req_addr;
            last_q  <= (bus.req_funct3 == F3_SH) ? 2'd1 : 2'd3;
            cnt     <= 2'd1;
            state   <= ST_BYTE;
          end
        end
        LD_HI: state <= IDLE;
        ST_BYTE: begin
          if (cnt == last_q) begin
            cnt   <= 2'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a byte-array datamemory model.
// Table of aligned/split accesses, then hand-written trace and mid-split reset sequences.
module tb_mem_access_sequencer;
  import lsu_pkg::*;

  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_sequencer_if #(.DM_ADDRESS(AW), .DATA_W(32)) bus();

  mem_access_sequencer #(.DM_ADDRESS(AW), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- datamemory model ----------------
  logic [7:0]  mem [512];
  logic        do_preload = 1'b0;
  logic [8:0]  ra0, ra1, ra2, ra3;
  logic [31:0] rd_word;

  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
      mem[9'h000] <= 8'h11; mem[9'h001] <= 8'h22; mem[9'h002] <= 8'h33; mem[9'h003] <= 8'h44;
      mem[9'h004] <= 8'h55; mem[9'h005] <= 8'h66; mem[9'h006] <= 8'h77; mem[9'h007] <= 8'h88;
      mem[9'h1FC] <= 8'hDD; mem[9'h1FD] <= 8'hCC; mem[9'h1FE] <= 8'hBB; mem[9'h1FF] <= 8'hAA;
    end else if (bus.mem_write) begin
      case (bus.mem_funct3)
        3'b000: mem[bus.mem_addr] <= bus.mem_wdata[7:0];
        3'b001: begin
          mem[bus.mem_addr]         <= bus.mem_wdata[7:0];
          mem[bus.mem_addr + 9'd1]  <= bus.mem_wdata[15:8];
        end
        default: begin
          mem[bus.mem_addr]         <= bus.mem_wdata[7:0];
          mem[bus.mem_addr + 9'd1]  <= bus.mem_wdata[15:8];
          mem[bus.mem_addr + 9'd2]  <= bus.mem_wdata[23:16];
          mem[bus.mem_addr + 9'd3]  <= bus.mem_wdata[31:24];
        end
      endcase
    end
  end

  always_comb begin
    ra0 = bus.mem_addr;
    ra1 = ra0 + 9'd1;
    ra2 = ra0 + 9'd2;
    ra3 = ra0 + 9'd3;
    case (bus.mem_funct3)
      3'b000:  rd_word = {{24{mem[ra0][7]}}, mem[ra0]};
      3'b001:  rd_word = {{16{mem[ra1][7]}}, mem[ra1], mem[ra0]};
      3'b100:  rd_word = {24'h0, mem[ra0]};
      3'b101:  rd_word = {16'h0, mem[ra1], mem[ra0]};
      default: rd_word = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};
    endcase
  end
  assign bus.mem_rdata = rd_word;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int rw_both  = 0;

  logic [8:0]  tr_addr [8];
  logic [31:0] tr_wd   [8];
  logic [2:0]  tr_f3   [8];
  logic        tr_rd   [8];
  logic        tr_wr   [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic preload();
    do_preload = 1'b1;
    @(posedge clk);
    #1;
    do_preload = 1'b0;
  endtask

  // Drive one request from posedge+1 and hold it until the cycle without stall completes.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                         input logic [31:0] wd, output int stalls,
                         output logic [31:0] rd, output logic got);
    bit done;
    done   = 1'b0;
    stalls = 0;
    rd     = '0;
    got    = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      tr_addr[c] = bus.mem_addr;
      tr_wd[c]   = bus.mem_wdata;
      tr_f3[c]   = bus.mem_funct3;
      tr_rd[c]   = bus.mem_read;
      tr_wr[c]   = bus.mem_write;
      if (bus.mem_read && bus.mem_write) rw_both++;
      if (bus.resp_valid) begin
        got = 1'b1;
        rd  = bus.resp_rdata;
      end
      if (bus.stall) stalls++;
      else done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    if (!done) stalls = 99;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wdata;
    int          stalls;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic we, input logic [2:0] f3,
                     input logic [8:0] addr, input logic [31:0] wdata,
                     input int stalls, input logic [31:0] rdata);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr;
    v.wdata = wdata; v.stalls = stalls; v.rdata = rdata;
    vecs.push_back(v);
  endtask

  initial begin
    int          st;
    logic [31:0] rd;
    logic        got;
    logic [8:0]  ea [4];
    logic [7:0]  eb [4];

    add("lw_004",       1'b0, F3_LW,  9'h004, 32'h0,        0, 32'h88776655);
    add("lw_000_b2b",   1'b0, F3_LW,  9'h000, 32'h0,        0, 32'h44332211);
    add("lw_001_split", 1'b0, F3_LW,  9'h001, 32'h0,        1, 32'h55443322);
    add("lh_006",       1'b0, F3_LH,  9'h006, 32'h0,        0, 32'hFFFF8877);
    add("lhu_003",      1'b0, F3_LHU, 9'h003, 32'h0,        1, 32'h00005544);
    add("lh_007",       1'b0, F3_LH,  9'h007, 32'h0,        1, 32'h00000088);
    add("lw_1ff_wrap",  1'b0, F3_LW,  9'h1FF, 32'h0,        1, 32'h332211AA);
    add("lhu_002_loc",  1'b0, F3_LHU, 9'h002, 32'h0,        0, 32'h00004433);
    add("lhu_006_loc",  1'b0, F3_LHU, 9'h006, 32'h0,        0, 32'h00008877);
    add("lb_007",       1'b0, F3_LB,  9'h007, 32'h0,        0, 32'hFFFFFF88);
    add("lbu_005",      1'b0, F3_LBU, 9'h005, 32'h0,        0, 32'h00000066);
    add("sw_002_split", 1'b1, F3_SW,  9'h002, 32'hDEADBEEF, 3, 32'h0);
    add("lw_000_post",  1'b0, F3_LW,  9'h000, 32'h0,        0, 32'hBEEF2211);
    add("lw_004_post",  1'b0, F3_LW,  9'h004, 32'h0,        0, 32'h8877DEAD);
    add("sh_005_split", 1'b1, F3_SH,  9'h005, 32'h00001234, 1, 32'h0);
    add("lw_004_sh",    1'b0, F3_LW,  9'h004, 32'h0,        0, 32'h881234AD);
    add("sh_008",       1'b1, F3_SH,  9'h008, 32'hCAFE55AA, 0, 32'h0);
    add("lw_008",       1'b0, F3_LW,  9'h008, 32'h0,        0, 32'h000055AA);
    add("sw_00c",       1'b1, F3_SW,  9'h00C, 32'h01020304, 0, 32'h0);
    add("lw_00c",       1'b0, F3_LW,  9'h00C, 32'h0,        0, 32'h01020304);
    add("lh_1ff_wrap",  1'b0, F3_LH,  9'h1FF, 32'h0,        1, 32'h000011AA);
    add("sw_1fe_wrap",  1'b1, F3_SW,  9'h1FE, 32'h0A0B0C0D, 3, 32'h0);
    add("lw_1fc_wrap",  1'b0, F3_LW,  9'h1FC, 32'h0,        0, 32'h0C0DCCDD);
    add("lw_000_wrap",  1'b0, F3_LW,  9'h000, 32'h0,        0, 32'hBEEF0A0B);

    // Reset: outputs quiet even with a live request on the bus.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_LW;
    bus.req_addr   = 9'h004;
    bus.req_wdata  = 32'h0;
    preload();
    @(negedge clk);
    check("rst_ld_mem_read",   32'(bus.mem_read),   32'd0);
    check("rst_ld_stall",      32'(bus.stall),      32'd0);
    check("rst_ld_resp_valid", 32'(bus.resp_valid), 32'd0);
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_SW;
    bus.req_addr   = 9'h001;
    @(negedge clk);
    check("rst_st_mem_write",  32'(bus.mem_write),  32'd0);
    check("rst_st_stall",      32'(bus.stall),      32'd0);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, st, rd, got);
      check({vecs[i].name, "_stalls"}, 32'(st), 32'(vecs[i].stalls));
      if (vecs[i].we) begin
        check({vecs[i].name, "_no_resp"}, 32'(got), 32'd0);
      end else begin
        check({vecs[i].name, "_resp"}, 32'(got), 32'd1);
        check({vecs[i].name, "_rdata"}, rd, vecs[i].rdata);
      end
    end

    // Split load issues LW at the base word, then the next word.
    preload();
    run_req(1'b0, F3_LW, 9'h001, 32'h0, st, rd, got);
    check("lw_001_addr0", 32'(tr_addr[0]), 32'h000);
    check("lw_001_addr1", 32'(tr_addr[1]), 32'h004);
    check("lw_001_f3_0",  32'(tr_f3[0]),   32'(F3_LW));
    check("lw_001_rd1",   32'(tr_rd[1]),   32'd1);

    run_req(1'b0, F3_LW, 9'h1FF, 32'h0, st, rd, got);
    check("wrap_addr0", 32'(tr_addr[0]), 32'h1FC);
    check("wrap_addr1", 32'(tr_addr[1]), 32'h000);
    check("wrap_rdata", rd, 32'h332211AA);

    // Split store: ascending byte addresses, one SB per cycle.
    ea = '{9'h002, 9'h003, 9'h004, 9'h005};
    eb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_req(1'b1, F3_SW, 9'h002, 32'hDEADBEEF, st, rd, got);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sw_trace_addr%0d", i), 32'(tr_addr[i]), 32'(ea[i]));
      check($sformatf("sw_trace_byte%0d", i), 32'(tr_wd[i][7:0]), 32'(eb[i]));
      check($sformatf("sw_trace_sb%0d", i), {28'h0, tr_wr[i], tr_f3[i]}, {28'h0, 1'b1, F3_SB});
    end

    // Reset in ST_BYTE after two bytes: the rest of the store never lands.
    preload();
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_SW;
    bus.req_addr   = 9'h001;
    bus.req_wdata  = 32'hDEADBEEF;
    @(negedge clk);
    check("mid_rst_b0_addr",  32'(bus.mem_addr), 32'h001);
    check("mid_rst_b0_stall", 32'(bus.stall),    32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_rst_b1_addr",  32'(bus.mem_addr),       32'h002);
    check("mid_rst_b1_byte",  32'(bus.mem_wdata[7:0]), 32'hBE);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall",     32'(bus.stall),     32'd0);
    check("mid_rst_mem_write", 32'(bus.mem_write), 32'd0);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_req(1'b0, F3_LW, 9'h000, 32'h0, st, rd, got);
    check("mid_rst_lw_000", rd, 32'h44BEEF11);
    run_req(1'b0, F3_LW, 9'h004, 32'h0, st, rd, got);
    check("mid_rst_lw_004", rd, 32'h88776655);

    check("rw_exclusive", 32'(rw_both), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
